// File: rtl/box_hit_judge.sv
// box_hit_judge: arms box-mapper targets, judges player hits within a timed window, tracks score/lives
module box_hit_judge #(
    parameter int WINDOW_CYCLES = 50000000,
    parameter int FLASH_CYCLES  = 12500000,
    parameter int MAX_LIVES     = 3,
    parameter int SCORE_W       = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset_signal,
    input  logic               box_valid,
    input  logic [2:0]         box,
    input  logic               hit_valid,
    input  logic [2:0]         hit_box,
    output logic [2:0]         target,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               hit_flash,
    output logic               miss_flash,
    output logic               game_over
);
    localparam int MAX_CNT = WINDOW_CYCLES > FLASH_CYCLES ? WINDOW_CYCLES : FLASH_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);
    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARMED, SHOW_HIT, SHOW_MISS, OVER} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count, count_nx;
    logic [2:0]         target_nx;
    logic [SCORE_W-1:0] score_nx;
    logic [1:0]         lives_nx;
    logic               hit_nx, miss_nx, over_nx;

    always_ff @(posedge CLOCK_50) begin
        if (reset_signal) begin
            state      <= IDLE;
            count      <= '0;
            target     <= '0;
            score      <= '0;
            lives      <= 2'(MAX_LIVES);
            hit_flash  <= 1'b0;
            miss_flash <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            target     <= target_nx;
            score      <= score_nx;
            lives      <= lives_nx;
            hit_flash  <= hit_nx;
            miss_flash <= miss_nx;
            game_over  <= over_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        target_nx = target;
        score_nx  = score;
        lives_nx  = lives;
        hit_nx    = hit_flash;
        miss_nx   = miss_flash;
        over_nx   = game_over;
        case (state)
            IDLE: if (box_valid && box >= 3'd2 && box <= 3'd5) begin
                state_nx  = ARMED;
                target_nx = box;
                count_nx  = '0;
            end
            // a matching hit outranks wrong hits, a fresh target and timeout
            ARMED: begin
                count_nx = count + 1'b1;
                if (hit_valid || box_valid || count == WIN_LAST) begin
                    target_nx = '0;
                    count_nx  = '0;
                    if (hit_valid && hit_box == target) begin
                        state_nx = SHOW_HIT;
                        hit_nx   = 1'b1;
                        score_nx = &score ? score : score + 1'b1;
                    end else begin
                        state_nx = SHOW_MISS;
                        miss_nx  = 1'b1;
                        lives_nx = lives == 2'd0 ? 2'd0 : lives - 2'd1;
                    end
                end
            end
            SHOW_HIT, SHOW_MISS: begin
                count_nx = count + 1'b1;
                if (count == FLASH_LAST) begin
                    count_nx = '0;
                    hit_nx   = 1'b0;
                    miss_nx  = 1'b0;
                    state_nx = lives == 2'd0 ? OVER : IDLE;
                    over_nx  = lives == 2'd0;
                end
            end
            OVER: begin
                over_nx   = 1'b1;
                target_nx = '0;
                hit_nx    = 1'b0;
                miss_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_box_hit_judge.sv
// tb_box_hit_judge: scoreboard bench; expected judgements queued at stimulus, popped on each flash rising edge
module tb_box_hit_judge;
    localparam int W = 16;
    localparam int F = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset_signal = 1'b1;
    logic       box_valid = 1'b0;
    logic [2:0] box = '0;
    logic       hit_valid = 1'b0;
    logic [2:0] hit_box = '0;
    logic [2:0] target;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit_flash, miss_flash, game_over;

    box_hit_judge #(.WINDOW_CYCLES(W), .FLASH_CYCLES(F), .MAX_LIVES(3), .SCORE_W(8)) dut (
        .CLOCK_50(CLOCK_50), .reset_signal(reset_signal),
        .box_valid(box_valid), .box(box),
        .hit_valid(hit_valid), .hit_box(hit_box),
        .target(target), .score(score), .lives(lives),
        .hit_flash(hit_flash), .miss_flash(miss_flash), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       hit;
        logic [7:0] score;
        logic [1:0] lives;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_score = 0;
    int   m_lives = 3;
    logic flash_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic push_exp(input logic hit);
        if (hit) m_score = m_score == 255 ? 255 : m_score + 1;
        else m_lives = m_lives == 0 ? 0 : m_lives - 1;
        q.push_back({hit, 8'(m_score), 2'(m_lives)});
    endtask

    task automatic arm(input logic [2:0] b);
        box_valid = 1'b1;
        box = b;
        cyc(1);
        box_valid = 1'b0;
    endtask

    task automatic strike(input logic [2:0] b);
        hit_valid = 1'b1;
        hit_box = b;
        cyc(1);
        hit_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_target"}, 32'(target), 0);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_lives"}, 32'(lives), 3);
        check({tag, "_flash"}, {hit_flash, miss_flash}, 0);
        check({tag, "_over"}, 32'(game_over), 0);
    endtask

    task automatic do_reset(input string tag);
        reset_signal = 1'b1;
        cyc(1);
        check_reset_state(tag);
        reset_signal = 1'b0;
        m_score = 0;
        m_lives = 3;
    endtask

    // each flash rising edge is one judgement produced by the DUT
    always @(negedge CLOCK_50) begin
        if ((hit_flash || miss_flash) && !flash_prev) begin
            check("flash_excl", {31'd0, hit_flash & miss_flash}, 0);
            if (q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("sb_kind", {hit_flash, miss_flash}, e.hit ? 2 : 1);
                check("sb_score", 32'(score), 32'(e.score));
                check("sb_lives", 32'(lives), 32'(e.lives));
                check("sb_target", 32'(target), 0);
            end
        end
        flash_prev = hit_flash | miss_flash;
    end

    initial begin
        cyc(2);
        do_reset("rst0");

        arm(3'd3);
        check("arm3_target", 32'(target), 3);
        cyc(3);
        push_exp(1'b1);
        strike(3'd3);
        cyc(3);
        check("hit_flash_held", 32'(hit_flash), 1);
        cyc(1);
        check("hit_flash_drop", 32'(hit_flash), 0);

        push_exp(1'b0);
        arm(3'd4);
        cyc(W - 1);
        check("window_last_target", 32'(target), 4);
        check("window_last_noflash", 32'(miss_flash), 0);
        cyc(1);
        check("timeout_flash", 32'(miss_flash), 1);
        cyc(F);
        check("timeout_flash_drop", 32'(miss_flash), 0);
        arm(3'd1);
        check("illegal1_target", 32'(target), 0);
        arm(3'd6);
        check("illegal6_target", 32'(target), 0);

        arm(3'd5);
        cyc(2);
        push_exp(1'b0);
        strike(3'd2);
        cyc(F);
        check("wrong_lives", 32'(lives), 1);
        check("wrong_over", 32'(game_over), 0);

        do_reset("rst1");
        arm(3'd2);
        cyc(1);
        push_exp(1'b0);
        arm(3'd5);
        check("newbox_target", 32'(target), 0);
        cyc(F + 2);
        check("newbox_never_armed", 32'(target), 0);

        arm(3'd3);
        cyc(W - 1);
        push_exp(1'b1);
        strike(3'd3);
        cyc(F);
        check("hit_timeout_lives", 32'(lives), 2);

        arm(3'd2);
        cyc(1);
        push_exp(1'b1);
        hit_valid = 1'b1;
        hit_box = 3'd2;
        box_valid = 1'b1;
        box = 3'd4;
        cyc(1);
        hit_valid = 1'b0;
        box_valid = 1'b0;
        cyc(F + 2);
        check("hit_box_same_target", 32'(target), 0);
        check("hit_box_same_score", 32'(score), 2);

        arm(3'd4);
        cyc(8);
        reset_signal = 1'b1;
        cyc(1);
        check_reset_state("rst_armed");
        reset_signal = 1'b0;
        m_score = 0;
        m_lives = 3;

        arm(3'd2);
        push_exp(1'b1);
        strike(3'd2);
        cyc(1);
        reset_signal = 1'b1;
        cyc(1);
        check_reset_state("rst_show_hit");
        reset_signal = 1'b0;
        m_score = 0;
        m_lives = 3;

        for (int i = 0; i < 3; i++) begin
            arm(3'd2);
            push_exp(1'b0);
            strike(3'd3);
            cyc(F - 1);
            check("over_during_flash", 32'(game_over), 0);
            cyc(1);
        end
        check("over_set", 32'(game_over), 1);
        check("over_lives", 32'(lives), 0);
        arm(3'd3);
        strike(3'd3);
        cyc(2);
        check("over_target", 32'(target), 0);
        check("over_score", 32'(score), 0);
        check("over_flash", {hit_flash, miss_flash}, 0);
        check("over_hold", 32'(game_over), 1);
        do_reset("rst_over");

        for (int i = 0; i < 256; i++) begin
            arm(3'd5);
            push_exp(1'b1);
            strike(3'd5);
            cyc(F);
        end
        check("score_saturate", 32'(score), 255);
        check("score_sat_lives", 32'(lives), 3);
        cyc(2);
        check("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
